// File: rtl/icache_line_fetcher_if.sv
// icache_line_fetcher_if: miss request, memory read channel and cache line-write port of the refill engine.
interface icache_line_fetcher_if #(
  parameter int INW = 512,
  parameter int ADDRW = 32,
  parameter int BEATW = 64
);
  logic             miss_in;
  logic [ADDRW-1:0] pc_in;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [ADDRW-1:0] mem_req_addr;
  logic             mem_rsp_valid;
  logic [BEATW-1:0] mem_rsp_data;
  logic             cache_write;
  logic [INW-1:0]   cache_data;
  logic [ADDRW-1:0] cache_base_addr;
  logic             busy;
  logic [7:0]       timeout_cnt;
  modport slave (
    input  miss_in, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output mem_req_valid, mem_req_addr, cache_write, cache_data, cache_base_addr, busy, timeout_cnt
  );
  modport master (
    output miss_in, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  mem_req_valid, mem_req_addr, cache_write, cache_data, cache_base_addr, busy, timeout_cnt
  );
endinterface

// File: rtl/icache_line_fetcher.sv
// icache_line_fetcher: I-cache refill FSM, one line request -> NUMBEATS beats -> single-cycle line write.
// Define ICF_TIMEOUT_EN to reissue the request after TIMEOUT beatless RECV cycles.
module icache_line_fetcher #(
  parameter int INW = 512,
  parameter int ADDRW = 32,
  parameter int BEATW = 64,
  parameter int NUMBEATS = INW / BEATW,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  icache_line_fetcher_if.slave bus
);
  localparam int CW = $clog2(NUMBEATS);
  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] beat;
  logic [ADDRW-1:0] base, line_base;
  logic [INW-BEATW-1:0] sh;
  logic [INW-1:0] line;
  logic last, tmo;
  if (INW % BEATW != 0 || NUMBEATS < 2 || NUMBEATS != INW / BEATW || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("icache_line_fetcher: unsupported parameter combination");
  end
  assign last = beat == CW'(NUMBEATS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.miss_in ? REQ : IDLE)
             : state == REQ  ? (bus.mem_req_ready ? RECV : REQ)
             : state == RECV ? (bus.mem_rsp_valid && last ? WRITE : tmo ? REQ : RECV)
             : IDLE;
  // Beats shift in from the bottom so beat 0 ends up in the line MSBs once all have arrived.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat <= '0;
      base <= '0;
      sh <= '0;
      line <= '0;
      line_base <= '0;
    end else begin
      if (state == IDLE && bus.miss_in) base <= bus.pc_in & ~ADDRW'(INW / 8 - 1);
      if (state == REQ) beat <= '0;
      if (state == RECV && bus.mem_rsp_valid) begin
        beat <= beat + CW'(1);
        sh <= (INW-BEATW)'({sh, bus.mem_rsp_data});
        if (last) begin
          line <= {sh, bus.mem_rsp_data};
          line_base <= base;
        end
      end
    end
  assign bus.mem_req_valid = state == REQ;
  assign bus.mem_req_addr = base;
  assign bus.cache_write = state == WRITE;
  assign bus.cache_data = line;
  assign bus.cache_base_addr = line_base;
  assign bus.busy = state != IDLE;
`ifdef ICF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle;
  logic [7:0] tcnt;
  assign tmo = state == RECV && !bus.mem_rsp_valid && idle == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idle <= '0;
      tcnt <= '0;
    end else begin
      idle <= state == RECV && !bus.mem_rsp_valid ? idle + TW'(1) : '0;
      if (tmo && tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
    end
  assign bus.timeout_cnt = tcnt;
`else
  assign tmo = 1'b0;
  assign bus.timeout_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_line_fetcher.sv
// tb_icache_line_fetcher: directed refill scenarios; expected line writes are queued at each miss
// and checked when cache_write fires.
`timescale 1ns/1ps
module tb_icache_line_fetcher;
`ifdef ICF_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  icache_line_fetcher_if #(.INW(512), .ADDRW(32), .BEATW(64)) bus ();
  icache_line_fetcher #(.INW(512), .ADDRW(32), .BEATW(64), .NUMBEATS(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  typedef struct {
    logic [31:0]  base;
    logic [511:0] line;
    int           t0;
    int           lat;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int vectors = 0, miscompares = 0, cyc = 0, reqs = 0, writes = 0;
  logic [63:0] bt [8];
  logic [63:0] stale [8];
  logic [511:0] exp_line, hold_line;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.mem_req_valid && bus.mem_req_ready) reqs++;
  end

  always @(negedge clk)
    if (rst_n && bus.cache_write) begin
      writes++;
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed write with %0d pending, expected >0", sb.size());
      end
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("write_data", bus.cache_data, me.line);
        chk("write_base", 512'(bus.cache_base_addr), 512'(me.base));
        if (me.lat >= 0) chk("write_latency", 512'(cyc - me.t0), 512'(me.lat));
      end
    end

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 512'(bus.mem_req_valid), 512'(1'b0));
    chk({tag, "_cache_write"}, 512'(bus.cache_write), 512'(1'b0));
    chk({tag, "_busy"}, 512'(bus.busy), 512'(1'b0));
    chk({tag, "_req_addr"}, 512'(bus.mem_req_addr), 512'(0));
    chk({tag, "_base_addr"}, 512'(bus.cache_base_addr), 512'(0));
    chk({tag, "_cache_data"}, bus.cache_data, 512'(0));
    chk({tag, "_timeout_cnt"}, 512'(bus.timeout_cnt), 512'(0));
  endtask

  task automatic do_miss(input logic [31:0] pc, input int lat);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[511-64*i -: 64] = bt[i];
    exp_line = l;
    @(negedge clk);
    sb.push_back('{base: pc & ~32'h3F, line: l, t0: cyc, lat: lat});
    bus.miss_in = 1'b1;
    bus.pc_in = pc;
    @(negedge clk);
    bus.miss_in = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] b [8], input int n, input int gap, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data = b[i];
      if (noise) begin
        bus.miss_in = ~bus.miss_in;
        bus.pc_in = 32'h2000;
      end
      for (int g = 0; g < gap && i < n - 1; g++) begin
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '1;
      end
    end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.miss_in = 1'b0;
  endtask

  task automatic wait_write(input int n0);
    int k = 0;
    while (writes == n0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    assert (writes == n0 + 1) else begin
      miscompares++;
      $error("FAIL write_wait: observed %0d writes expected %0d", writes - n0, 1);
    end
  endtask

  initial begin
    int r0, k;
    bus.miss_in = 1'b0;
    bus.pc_in = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    // basic refill
    for (int i = 0; i < 8; i++) bt[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    r0 = writes;
    do_miss(32'h0000_1046, 10);
    chk("basic_req_valid", 512'(bus.mem_req_valid), 512'(1'b1));
    chk("basic_req_addr", 512'(bus.mem_req_addr), 512'(32'h1040));
    send_beats(bt, 8, 0, 1'b0);
    wait_write(r0);
    chk("basic_top_beat", 512'(bus.cache_data[511:448]), 512'(64'h1111_1111_1111_1111));
    chk("basic_bottom_beat", 512'(bus.cache_data[63:0]), 512'(64'h8888_8888_8888_8888));
    chk("basic_base", 512'(bus.cache_base_addr), 512'(32'h1040));
    @(negedge clk);
    chk("basic_idle_busy", 512'(bus.busy), 512'(1'b0));
    chk("basic_hold_data", bus.cache_data, exp_line);
    // back-pressure then gapped beats
    bus.mem_req_ready = 1'b0;
    r0 = reqs;
    k = writes;
    do_miss(32'h0000_1046, 20);
    for (int s = 0; s < 3; s++) begin
      chk("stall_req_valid", 512'(bus.mem_req_valid), 512'(1'b1));
      chk("stall_req_addr", 512'(bus.mem_req_addr), 512'(32'h1040));
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    send_beats(bt, 8, 1, 1'b0);
    wait_write(k);
    chk("stall_req_count", 512'(reqs - r0), 512'(1));
    // busy filtering
    for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
    r0 = reqs;
    k = writes;
    do_miss(32'h0000_1040, 10);
    send_beats(bt, 8, 0, 1'b1);
    wait_write(k);
    repeat (3) @(negedge clk);
    chk("filter_req_count", 512'(reqs - r0), 512'(1));
    chk("filter_busy", 512'(bus.busy), 512'(1'b0));
    chk("filter_base", 512'(bus.cache_base_addr), 512'(32'h1040));
    // stray responses in IDLE and REQ
    hold_line = exp_line;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("stray_idle_busy", 512'(bus.busy), 512'(1'b0));
    chk("stray_idle_req", 512'(bus.mem_req_valid), 512'(1'b0));
    chk("stray_idle_data", bus.cache_data, hold_line);
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
    k = writes;
    do_miss(32'h0000_3FFF, 12);
    for (int s = 0; s < 2; s++) begin
      chk("stray_req_busy", 512'(bus.busy), 512'(1'b1));
      chk("stray_req_addr", 512'(bus.mem_req_addr), 512'(32'h3FC0));
      chk("stray_req_data", bus.cache_data, hold_line);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    send_beats(bt, 8, 0, 1'b0);
    wait_write(k);
    // reset in the middle of RECV
    for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
    do_miss(32'h0000_5008, 10);
    send_beats(bt, 4, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) bt[i] = {$urandom, $urandom};
    k = writes;
    do_miss(32'h0000_5008, 10);
    send_beats(bt, 8, 0, 1'b0);
    wait_write(k);
`ifdef ICF_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      bt[i] = {$urandom, $urandom};
      stale[i] = {$urandom, $urandom};
    end
    k = writes;
    do_miss(32'h0000_7010, -1);
    send_beats(stale, 2, 0, 1'b0);
    r0 = 0;
    while (!bus.mem_req_valid && r0 < 40) begin
      @(negedge clk);
      r0++;
    end
    chk("tmo_idle_cycles", 512'(r0), 512'(16));
    chk("tmo_req_addr", 512'(bus.mem_req_addr), 512'(32'h7000));
    chk("tmo_count", 512'(bus.timeout_cnt), 512'(1));
    send_beats(bt, 8, 0, 1'b0);
    wait_write(k);
`else
    chk("tmo_tied_zero", 512'(bus.timeout_cnt), 512'(0));
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 512'(sb.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
